// File: rtl/ebm_pkg.sv
// ebm_pkg: shared definitions for the egress buffer manager.
//   - beat tag encodings carried in the top two bits of every data beat
//   - FSM state encoding
//   - saturating increment helper used by the statistics counters
package ebm_pkg;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    WAIT_S = 2'd1,
    TRAN_S = 2'd2
  } ebm_state_e;

  localparam int unsigned SAT_W = 64;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/ebm_mq_if.sv
// ebm_mq_if: bundle of every non-clock/reset signal of ebm_mq.
//   in_*  : driven by eos / data_cache towards the buffer manager
//   out_* : driven by the buffer manager towards data_cache / goe / stats
// slave modport is the buffer manager side, master the environment side.
interface ebm_mq_if #(
  parameter int DATA_W = 134,
  parameter int ID_W   = 8,
  parameter int CNT_W  = 32
);
  logic [ID_W-1:0]   in_ebm_md;
  logic              in_ebm_md_wr;
  logic              in_ebm_bandwidth_discard;
  logic              out_ebm_md_full;
  logic [ID_W-1:0]   out_ebm_ID;
  logic              out_ebm_ID_wr;
  logic [DATA_W-1:0] in_ebm_data;
  logic              in_ebm_data_wr;
  logic [DATA_W-1:0] out_ebm_data;
  logic              out_ebm_data_wr;
  logic              out_ebm_valid;
  logic              out_ebm_valid_wr;
  logic [CNT_W-1:0]  out_fwd_cnt;
  logic [CNT_W-1:0]  out_drop_cnt;
  logic [CNT_W-1:0]  out_ovf_cnt;
  logic [CNT_W-1:0]  out_tmo_cnt;

  modport slave (
    input  in_ebm_md, in_ebm_md_wr, in_ebm_bandwidth_discard,
    input  in_ebm_data, in_ebm_data_wr,
    output out_ebm_md_full, out_ebm_ID, out_ebm_ID_wr,
    output out_ebm_data, out_ebm_data_wr, out_ebm_valid, out_ebm_valid_wr,
    output out_fwd_cnt, out_drop_cnt, out_ovf_cnt, out_tmo_cnt
  );

  modport master (
    output in_ebm_md, in_ebm_md_wr, in_ebm_bandwidth_discard,
    output in_ebm_data, in_ebm_data_wr,
    input  out_ebm_md_full, out_ebm_ID, out_ebm_ID_wr,
    input  out_ebm_data, out_ebm_data_wr, out_ebm_valid, out_ebm_valid_wr,
    input  out_fwd_cnt, out_drop_cnt, out_ovf_cnt, out_tmo_cnt
  );
endinterface

// File: rtl/ebm_md_fifo.sv
// ebm_md_fifo: synchronous first-word-fall-through FIFO for {discard, id}.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write wdata_i (caller only pushes when not full or popping)
//   pop_i      : consume rdata_o (caller only pops when not empty)
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o     : registered, occupancy == DEPTH
//   empty_o    : registered, occupancy == 0
module ebm_md_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: pointers and flags define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/ebm_mq.sv
// ebm_mq: egress buffer manager between eos, data_cache and goe.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ebm_mq_if.slave carrying metadata input, read-ID issue,
//                data_cache beats in, goe beats/valid out and statistics.
// Queued IDs are issued one at a time; the returned packet is forwarded to
// goe with one cycle latency or silently dropped when its discard flag is set.
//
// state  | meaning
// IDLE_S | no packet open; pop next ID from the metadata FIFO and issue it
// WAIT_S | ID issued, waiting (bounded by TIMEOUT) for the first beat
// TRAN_S | packet open, passing beats until the tail
module ebm_mq
  import ebm_pkg::*;
#(
  parameter int DATA_W   = 134,
  parameter int ID_W     = 8,
  parameter int MD_DEPTH = 4,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 32
) (
  input logic     clk,
  input logic     rst_n,
  ebm_mq_if.slave bus
);
  localparam int MD_W  = ID_W + 1;
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  ebm_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              disc_q, disc_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              id_wr_q, id_wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_wr_q, data_wr_d;
  logic              valid_q, valid_d;
  logic              valid_wr_q, valid_wr_d;
  logic [CNT_W-1:0]  fwd_q, fwd_d, drop_q, drop_d, ovf_q, ovf_d, tmo_q, tmo_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MD_W-1:0]   fifo_rd;
  logic              beat_acc, is_tail, tmo_hit;

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign fifo_pop  = (state_q == IDLE_S) && !fifo_empty;
  assign fifo_push = bus.in_ebm_md_wr && (!fifo_full || fifo_pop);
  assign is_tail   = (bus.in_ebm_data[DATA_W-1 -: 2] == TAG_TAIL);

  ebm_md_fifo #(.WIDTH(MD_W), .DEPTH(MD_DEPTH)) u_md_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({bus.in_ebm_bandwidth_discard, bus.in_ebm_md}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    disc_d     = disc_q;
    id_d       = id_q;
    id_wr_d    = 1'b0;
    data_d     = '0;
    data_wr_d  = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    beat_acc   = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (!fifo_empty) begin
          id_d    = fifo_rd[ID_W-1:0];
          id_wr_d = 1'b1;
          disc_d  = fifo_rd[ID_W];
          timer_d = '0;
          state_d = WAIT_S;
        end
      end
      WAIT_S: begin
        if (bus.in_ebm_data_wr) begin
          beat_acc = 1'b1;
          state_d  = is_tail ? IDLE_S : TRAN_S;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = IDLE_S;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      TRAN_S: begin
        if (bus.in_ebm_data_wr) begin
          beat_acc = 1'b1;
          if (is_tail) state_d = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase

    if (beat_acc && !disc_q) begin
      data_d     = bus.in_ebm_data;
      data_wr_d  = 1'b1;
      valid_d    = is_tail;
      valid_wr_d = is_tail;
    end
  end

  always_comb begin
    fwd_d  = fwd_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    tmo_d  = tmo_q;
    if (beat_acc && is_tail && !disc_q) fwd_d  = CNT_W'(sat_inc(64'(fwd_q), CNT_W));
    if (beat_acc && is_tail && disc_q)  drop_d = CNT_W'(sat_inc(64'(drop_q), CNT_W));
    if (bus.in_ebm_md_wr && fifo_full && !fifo_pop) ovf_d = CNT_W'(sat_inc(64'(ovf_q), CNT_W));
    if (tmo_hit) tmo_d = CNT_W'(sat_inc(64'(tmo_q), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE_S;
      timer_q    <= '0;
      disc_q     <= 1'b0;
      id_q       <= '0;
      id_wr_q    <= 1'b0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      fwd_q      <= '0;
      drop_q     <= '0;
      ovf_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      disc_q     <= disc_d;
      id_q       <= id_d;
      id_wr_q    <= id_wr_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      fwd_q      <= fwd_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.out_ebm_md_full  = fifo_full;
  assign bus.out_ebm_ID       = id_q;
  assign bus.out_ebm_ID_wr    = id_wr_q;
  assign bus.out_ebm_data     = data_q;
  assign bus.out_ebm_data_wr  = data_wr_q;
  assign bus.out_ebm_valid    = valid_q;
  assign bus.out_ebm_valid_wr = valid_wr_q;
  assign bus.out_fwd_cnt      = fwd_q;
  assign bus.out_drop_cnt     = drop_q;
  assign bus.out_ovf_cnt      = ovf_q;
  assign bus.out_tmo_cnt      = tmo_q;
endmodule

// File: doc/ebm_mq.md
Name: ebm_mq

Overview:
Parametrised egress buffer manager. It sits between eos (scheduler), data_cache (packet store) and goe (output engine). Scheduled packet IDs and their discard decisions from eos are queued in a metadata FIFO. The block issues one read ID at a time to data_cache, forwards or silently drops the returned packet beats, and keeps statistics. Over the previous single-entry block it adds:
- per-packet (not sticky) discard,
- an ID queue with a full indication,
- a read-return timeout,
- saturating counters.

Parameters:
DATA_W, 134, packet beat width; bits [DATA_W-1:DATA_W-2] are the beat tag (01 head, 11 body, 10 tail).
ID_W, 8, packet ID width.
MD_DEPTH, 4, metadata FIFO depth; power of two, ≥2.
TIMEOUT, 255, max cycles WAIT_S waits for the first beat; ≥1.
CNT_W, 32, statistics counter width.

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_ebm_md  in  ID_W  packet ID from eos
in_ebm_md_wr  in  1  ID write strobe
in_ebm_bandwidth_discard  in  1  discard flag, qualified by in_ebm_md_wr
out_ebm_md_full  out  1  metadata FIFO full
out_ebm_ID  out  ID_W  read ID to data_cache
out_ebm_ID_wr  out  1  read ID strobe, one cycle
in_ebm_data  in  DATA_W  beat from data_cache
in_ebm_data_wr  in  1  beat strobe
out_ebm_data  out  DATA_W  beat to goe
out_ebm_data_wr  out  1  beat strobe to goe
out_ebm_valid  out  1  packet-valid flag
out_ebm_valid_wr  out  1  packet-valid strobe
out_fwd_cnt  out  CNT_W  packets forwarded
out_drop_cnt  out  CNT_W  packets discarded
out_ovf_cnt  out  CNT_W  metadata writes lost to a full FIFO
out_tmo_cnt  out  CNT_W  read timeouts

Behaviour:
Reset and clocking:
- One clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- All outputs and counters reset to 0. FIFO is empty. State is IDLE_S.
- Reset asserted mid-packet: the packet is abandoned, no tail or valid strobe is emitted, queued IDs are lost.

Metadata FIFO:
- Each entry is {discard, id}. Push on in_ebm_md_wr when not full.
- in_ebm_md_wr while full with no pop that cycle: entry lost, out_ovf_cnt +1.
- Push and pop in the same cycle while full: both succeed.
- out_ebm_md_full is registered and reflects the current occupancy == MD_DEPTH.

State machine:
- IDLE_S: if FIFO non-empty, pop the entry. Drive out_ebm_ID = id and out_ebm_ID_wr = 1 for exactly one cycle, latch discard into disc_r, reset the timer, go to WAIT_S. Otherwise out_ebm_ID_wr = 0.
- WAIT_S:
  - On in_ebm_data_wr: register the beat, go to TRAN_S.
  - Else the timer increments. When the timer reaches TIMEOUT: out_tmo_cnt +1, return to IDLE_S with no output strobes.
- TRAN_S: every cycle with in_ebm_data_wr, register the beat. Cycles without in_ebm_data_wr are gaps (no output, stay in TRAN_S).
  - On a beat with tag 10 (tail): pulse out_ebm_valid = 1 and out_ebm_valid_wr = 1 together with the tail beat, unless disc_r is set. Increment out_fwd_cnt, or out_drop_cnt if disc_r. Go to IDLE_S.
  - A single-beat packet (head tag 01 in WAIT_S followed by tail) follows the normal path. A first beat already tagged 10 ends the packet immediately from WAIT_S.

Output beat rules:
- out_ebm_data_wr = in_ebm_data_wr & ~disc_r, one cycle latency.
- out_ebm_data is 0 when no beat is written.

Next-ID issue:
- The earliest next ID issue is the cycle after the tail enters IDLE_S. There is no ID overlap with an open packet.

Counters:
- All counters saturate at all-ones; no wrap.

Decomposition:
- Shared package ebm_pkg:
  - tag localparams TAG_HEAD = 2'b01, TAG_BODY = 2'b11, TAG_TAIL = 2'b10;
  - state encoding IDLE_S / WAIT_S / TRAN_S;
  - a saturating-increment function.
- Sub-module ebm_md_fifo, parametrised by width (ID_W+1) and depth: synchronous, first-word-fall-through, with registered full/empty.

Test Plan:
1. Three IDs 0x05, 0x06, 0x07 written back-to-back, discard = 0; data_cache returns 3-beat packets → three out_ebm_ID_wr pulses in order 05, 06, 07. Each packet appears on out_ebm_data with 1-cycle latency. Three out_ebm_valid_wr pulses; out_fwd_cnt = 3.
2. ID 0x10 with discard = 1, then ID 0x11 with discard = 0 → no data or valid strobes for packet 0x10. Packet 0x11 is forwarded intact. out_drop_cnt = 1, out_fwd_cnt = 1 (discard does not persist across packets).
3. MD_DEPTH+2 = 6 md writes while data_cache is stalled → out_ebm_md_full = 1 after 4 entries remain queued; out_ovf_cnt = 1 (one entry is popped on the first cycle).
4. ID 0x20 issued, no data returned for TIMEOUT cycles → out_tmo_cnt = 1, the FSM returns to IDLE_S and issues the next queued ID.
5. Single-beat packet tagged 10, plus a 4-beat packet with a 2-cycle gap before the body → valid pulses aligned with the tail in both cases; no output strobes during the gap.
6. rst_n low for 1 cycle mid-body of a 5-beat packet → all outputs 0 next cycle, no valid strobe, FIFO empty, counters 0.
